syst_row: RTL and testbench

- Parametrised successor to the single systolic MAC node: a row of N_PE multiply-accumulate nodes in transposed systolic FIR form.
- Streams samples with valid/ready backpressure and loads its weights serially through an internal load FSM.
- Produces one filtered sample per accepted input.
- Sits between the windowing stage and the FFT butterfly datapath as a programmable pre-filter / DFT-bin correlator.

---
 rtl/syst_pkg.sv | 14 +
 rtl/syst_pe.sv | 29 ++
 rtl/syst_row.sv | 88 ++++++++
 tb/tb_syst_row.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/syst_pkg.sv
// syst_pkg: shared FSM states, default accumulator width and output narrowing helper for syst_row
package syst_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;
  function automatic int acc_width(int xw, int ww, int n);
    return xw + ww + $clog2(n);
  endfunction
  function automatic logic signed [127:0] narrow(logic signed [127:0] v, int ow, logic sat);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (ow - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return !sat ? v : v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/syst_pe.sv
// syst_pe: one transposed-form MAC node holding a weight register and a partial-sum register
module syst_pe #(
  parameter int X_WIDTH = 16,
  parameter int W_WIDTH = 16,
  parameter int ACC_WIDTH = 34
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        w_we,
  input  logic signed [W_WIDTH-1:0]   w_d,
  input  logic signed [X_WIDTH-1:0]   x,
  input  logic                        en,
  input  logic                        clr,
  input  logic signed [ACC_WIDTH-1:0] s_in,
  output logic signed [ACC_WIDTH-1:0] s_o
);
  logic signed [W_WIDTH-1:0] w;
  logic signed [X_WIDTH+W_WIDTH-1:0] p;
  assign p = x * w;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      w <= '0;
      s_o <= '0;
    end else begin
      if (w_we) w <= w_d;
      if (clr) s_o <= '0;
      else if (en) s_o <= ACC_WIDTH'(p) + s_in;
    end
endmodule

// File: rtl/syst_row.sv
// syst_row: N_PE-tap transposed systolic FIR row with serial weight load; define SYST_ROW_SAT_EN for saturating narrowing and sat_o
module syst_row
  import syst_pkg::*;
#(
  parameter int N_PE = 4,
  parameter int X_WIDTH = 16,
  parameter int W_WIDTH = 16,
  parameter int ACC_WIDTH = acc_width(X_WIDTH, W_WIDTH, N_PE),
  parameter int OUT_WIDTH = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        w_load_start,
  input  logic signed [W_WIDTH-1:0]   w_i,
  input  logic                        w_valid_i,
  input  logic signed [X_WIDTH-1:0]   x_i,
  input  logic                        valid_x_i,
  output logic                        ready_x_o,
  output logic signed [OUT_WIDTH-1:0] psumm_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        busy_o
`ifdef SYST_ROW_SAT_EN
  ,
  output logic                        sat_o
`endif
);
  localparam int CW = $clog2(N_PE);
  state_t state;
  logic [CW-1:0] cnt;
  logic [N_PE:0][ACC_WIDTH-1:0] s;
  logic signed [ACC_WIDTH-1:0] sh;
  logic signed [127:0] ext;
  logic load_we;
  logic last;
  logic accept;
  assign load_we = state == ST_LOAD && w_valid_i && !w_load_start;
  assign last = cnt == CW'(N_PE - 1);
  assign ready_x_o = state == ST_RUN && (!valid_o || ready_i);
  assign accept = valid_x_i && ready_x_o && !w_load_start;
  assign s[N_PE] = '0;
  for (genvar k = 0; k < N_PE; k++) begin : g_pe
    syst_pe #(
      .X_WIDTH(X_WIDTH),
      .W_WIDTH(W_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_pe (
      .clk(clk),
      .rstn(rstn),
      .w_we(load_we && cnt == CW'(k)),
      .w_d(w_i),
      .x(x_i),
      .en(accept),
      .clr(w_load_start || (load_we && last)),
      .s_in(s[k+1]),
      .s_o(s[k])
    );
  end
  assign sh = $signed(s[0]) >>> OUT_SHIFT;
  assign ext = {{(128-ACC_WIDTH){sh[ACC_WIDTH-1]}}, sh};
`ifdef SYST_ROW_SAT_EN
  assign psumm_o = OUT_WIDTH'(narrow(ext, OUT_WIDTH, 1'b1));
  assign sat_o = valid_o && narrow(ext, OUT_WIDTH, 1'b1) != ext;
`else
  assign psumm_o = OUT_WIDTH'(narrow(ext, OUT_WIDTH, 1'b0));
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ST_IDLE;
      cnt <= '0;
      valid_o <= 1'b0;
      busy_o <= 1'b1;
    end else begin
      valid_o <= accept || (valid_o && !ready_i && !w_load_start);
      if (w_load_start) begin
        state <= ST_LOAD;
        cnt <= '0;
        busy_o <= 1'b1;
      end else if (load_we) begin
        cnt <= cnt + 1'b1;
        if (last) begin
          state <= ST_RUN;
          busy_o <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_syst_row.sv
// tb_syst_row: randomized and directed checks of syst_row against a direct-convolution reference model
module tb_syst_row;
  localparam int N = 4;
  localparam int OW = 16;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN = 2;
  logic clk = 0;
  logic rstn = 0;
  logic w_load_start = 0;
  logic w_valid_i = 0;
  logic valid_x_i = 0;
  logic ready_i = 0;
  logic signed [15:0] w_i = '0;
  logic signed [15:0] x_i = '0;
  logic ready_x_o;
  logic valid_o;
  logic busy_o;
  logic signed [OW-1:0] psumm_o;
`ifdef SYST_ROW_SAT_EN
  logic sat_o;
`endif
  int checks = 0;
  int errors = 0;
  int mode = M_IDLE;
  int cnt = 0;
  longint w_m [N];
  longint hist [$];
  logic vld_m = 0;
  logic sat_m = 0;
  longint out_m = 0;
  always #5 clk = ~clk;
  syst_row #(.N_PE(N), .OUT_WIDTH(OW)) dut (
    .clk(clk),
    .rstn(rstn),
    .w_load_start(w_load_start),
    .w_i(w_i),
    .w_valid_i(w_valid_i),
    .x_i(x_i),
    .valid_x_i(valid_x_i),
    .ready_x_o(ready_x_o),
    .psumm_o(psumm_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy_o(busy_o)
`ifdef SYST_ROW_SAT_EN
    ,
    .sat_o(sat_o)
`endif
  );
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint narrow_m(longint v);
    longint hi;
    logic signed [OW-1:0] t;
    hi = (longint'(1) << (OW - 1)) - 1;
    t = v[OW-1:0];
`ifdef SYST_ROW_SAT_EN
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
`else
    return longint'(t);
`endif
  endfunction
  task automatic tick(input int ls, input int wv, input int wd, input int vx, input int xd, input int rdy);
    logic er;
    longint sum;
    w_load_start = 1'(ls);
    w_valid_i = 1'(wv);
    w_i = 16'(wd);
    valid_x_i = 1'(vx);
    x_i = 16'(xd);
    ready_i = 1'(rdy);
    #3;
    er = mode == M_RUN && (!vld_m || ready_i);
    chk("ready_x_o", ready_x_o, er);
    if (w_load_start) begin
      mode = M_LOAD;
      cnt = 0;
      vld_m = 0;
      hist.delete();
    end else if (mode == M_LOAD && w_valid_i) begin
      w_m[cnt] = w_i;
      cnt++;
      if (cnt == N) mode = M_RUN;
    end else if (mode == M_RUN && valid_x_i && er) begin
      hist.push_front(x_i);
      if (hist.size() > N) void'(hist.pop_back());
      sum = 0;
      foreach (hist[k]) sum += w_m[k] * hist[k];
      out_m = narrow_m(sum);
      sat_m = out_m != sum;
      vld_m = 1;
    end else if (mode == M_RUN && ready_i) vld_m = 0;
    @(posedge clk);
    #1;
    chk("valid_o", valid_o, vld_m);
    chk("busy_o", busy_o, mode != M_RUN);
    if (vld_m) chk("psumm_o", psumm_o, out_m);
`ifdef SYST_ROW_SAT_EN
    chk("sat_o", sat_o, vld_m && sat_m);
`endif
  endtask
  task automatic load(input int a0, input int a1, input int a2, input int a3);
    int wa [4] = '{a0, a1, a2, a3};
    tick(1, 0, 0, int'($urandom_range(1)), int'($urandom_range(65535)), 1);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(2) == 0) tick(0, 0, 0, 1, int'($urandom_range(65535)), 1);
      tick(0, 1, wa[i], 1, int'($urandom_range(65535)), 1);
    end
  endtask
  function automatic int rnd_x();
    return $urandom_range(1) == 1 ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(20)) - 10;
  endfunction
  function automatic int rnd_w();
    return int'($urandom_range(65535)) - 32768;
  endfunction
  initial begin
    int fir_exp [5] = '{1, 2, 3, 4, 0};
    int rl_exp [4] = '{0, 0, 0, 9};
    @(posedge clk);
    #1;
    chk("reset_valid", valid_o, 0);
    chk("reset_ready", ready_x_o, 0);
    chk("reset_psumm", psumm_o, 0);
    chk("reset_busy", busy_o, 1);
    #2;
    rstn = 1;
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 7, 1);
    load(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1, i == 0 ? 1 : 0, 1);
      chk("fir", psumm_o, fir_exp[i]);
    end
    tick(0, 0, 0, 1, 5, 1);
    tick(0, 0, 0, 1, 6, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 7, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 1, i < 2 ? 7 + i : 0, 1);
    load(1, 1, 1, 1);
    tick(0, 0, 0, 1, 2, 1);
    chk("bubble_out1", psumm_o, 2);
    tick(0, 0, 0, 0, 3, 1);
    chk("bubble_gap1", valid_o, 0);
    tick(0, 0, 0, 1, 5, 1);
    chk("bubble_out2", psumm_o, 7);
    tick(0, 0, 0, 0, 4, 1);
    chk("bubble_gap2", valid_o, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, rnd_x(), 1);
    load(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 1, i == 0 ? 9 : 0, 1);
      chk("reload", psumm_o, rl_exp[i]);
    end
    load(rnd_w(), rnd_w(), rnd_w(), rnd_w());
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(59) == 0) load(rnd_w(), rnd_w(), rnd_w(), rnd_w());
      else tick(0, 0, 0, int'($urandom_range(3) != 0), rnd_x(), int'($urandom_range(3) != 0));
    end
    w_load_start = 0;
    w_valid_i = 0;
    valid_x_i = 0;
    #2;
    rstn = 0;
    #1;
    chk("areset_valid", valid_o, 0);
    chk("areset_ready", ready_x_o, 0);
    chk("areset_psumm", psumm_o, 0);
    chk("areset_busy", busy_o, 1);
    mode = M_IDLE;
    vld_m = 0;
    hist.delete();
    foreach (w_m[k]) w_m[k] = 0;
    #3;
    rstn = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, rnd_x(), 1);
    load(32767, 0, 0, 0);
    tick(0, 0, 0, 1, 32767, 1);
`ifdef SYST_ROW_SAT_EN
    chk("narrow_sat", psumm_o, 32767);
    chk("narrow_flag", sat_o, 1);
`else
    chk("narrow_wrap", psumm_o, 1);
`endif
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
